// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and transmit FSM state encodings.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 12;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic logic [63:0] status_word(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [8:0] cnt
    );
        logic [63:0] w;
        w                      = 64'd0;
        w[ST_FULL]             = full;
        w[ST_EMPTY]            = empty;
        w[ST_BUSY]             = busy;
        w[ST_OVF]              = ovf;
        w[ST_CNT_HI:ST_CNT_LO] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // occupancy update from accepted push/pop
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            count_r <= count_nxt_s;
        end
    end

    // storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/uart_tx_bus.sv
// Bus-attached 8N1 UART transmitter: register decode, byte FIFO, serialiser FSM
// and a registered transmit-idle interrupt.
module uart_tx_bus
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_address,
    input  logic [63:0] bus_write_data,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic        uart_tx,
    output logic        tx_irq
);
    localparam int            DIV       = CLK_HZ / BAUD;
    localparam int            CW        = $clog2(DIV);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    logic        sel_s;
    logic [1:0]  off_s;
    logic        wr_en_q_r, rd_en_q_r;
    logic        wr_pulse_s, rd_pulse_s;
    logic        push_req_s, push_s, pop_s;
    logic        ovf_r, ovf_nxt_s, ovf_set_s, ovf_clr_s;
    logic        irq_en_r, irq_en_nxt_s, ctrl_wr_s;
    logic [63:0] rdata_r, rdata_nxt_s, rd_word_s;
    logic [7:0]  fifo_data_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [AW:0] fifo_count_s;

    logic [1:0]    state_r, state_nxt_s;
    logic [CW-1:0] baud_cnt_r, baud_nxt_s;
    logic          baud_done_s;
    logic [2:0]    bit_idx_r, bit_nxt_s;
    logic [7:0]    shift_r, shift_nxt_s;
    logic          tx_r, tx_nxt_s;
    logic          irq_r, irq_nxt_s;
    logic          unused_s;

    assign unused_s = ^{bus_write_data[63:8], bus_address[2:0]};

    assign sel_s       = (bus_address[63:5] == BASE_ADDR[63:5]);
    assign off_s       = bus_address[4:3];
    assign wr_pulse_s  = bus_write_enable & ~wr_en_q_r & sel_s;
    assign rd_pulse_s  = bus_read_enable & ~rd_en_q_r & sel_s;
    assign push_req_s  = wr_pulse_s & (off_s == OFF_TXDATA);
    // A byte arriving at a full FIFO is lost even if the shifter pops this cycle.
    assign push_s      = push_req_s & ~fifo_full_s;
    assign ovf_set_s   = push_req_s & fifo_full_s;
    assign ovf_clr_s   = rd_pulse_s & (off_s == OFF_STATUS);
    assign ctrl_wr_s   = wr_pulse_s & (off_s == OFF_CTRL);
    assign baud_done_s = (baud_cnt_r == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .push_data (bus_write_data[7:0]),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // register-file next values and read mux
    always_comb begin
        ovf_nxt_s    = ovf_r;
        irq_en_nxt_s = irq_en_r;
        rd_word_s    = 64'd0;
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
        if (ctrl_wr_s) begin
            irq_en_nxt_s = bus_write_data[0];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
        if (sel_s) begin
            case (off_s)
                OFF_STATUS: rd_word_s = status_word(fifo_full_s, fifo_empty_s,
                                                    (state_r != S_IDLE), ovf_r,
                                                    9'(fifo_count_s));
                OFF_CTRL:   rd_word_s = {63'd0, irq_en_r};
                default:    rd_word_s = 64'd0;
            endcase
        end else begin
            rd_word_s = 64'd0;
        end
        if (bus_read_enable) begin
            rdata_nxt_s = rd_word_s;
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // bus-side registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q_r <= 1'b0;
            rd_en_q_r <= 1'b0;
            ovf_r     <= 1'b0;
            irq_en_r  <= 1'b0;
            rdata_r   <= 64'd0;
        end else begin
            wr_en_q_r <= bus_write_enable;
            rd_en_q_r <= bus_read_enable;
            ovf_r     <= ovf_nxt_s;
            irq_en_r  <= irq_en_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) state_nxt_s = S_START;
                else               state_nxt_s = S_IDLE;
            end
            S_START: begin
                if (baud_done_s) state_nxt_s = S_DATA;
                else             state_nxt_s = S_START;
            end
            S_DATA: begin
                if (baud_done_s && (bit_idx_r == 3'd7)) state_nxt_s = S_STOP;
                else                                    state_nxt_s = S_DATA;
            end
            S_STOP: begin
                if (baud_done_s) state_nxt_s = fifo_empty_s ? S_IDLE : S_START;
                else             state_nxt_s = S_STOP;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM outputs: pop, shifter/counters and the line level for the next state
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            S_IDLE:  pop_s = ~fifo_empty_s;
            S_STOP:  pop_s = baud_done_s & ~fifo_empty_s;
            default: pop_s = 1'b0;
        endcase

        if (pop_s) begin
            shift_nxt_s = fifo_data_s;
            bit_nxt_s   = 3'd0;
        end else if ((state_r == S_DATA) && baud_done_s) begin
            shift_nxt_s = {1'b0, shift_r[7:1]};
            bit_nxt_s   = bit_idx_r + 3'd1;
        end else begin
            shift_nxt_s = shift_r;
            bit_nxt_s   = bit_idx_r;
        end

        if ((state_r == S_IDLE) || baud_done_s) begin
            baud_nxt_s = '0;
        end else begin
            baud_nxt_s = baud_cnt_r + CW'(1'b1);
        end

        // Line level is computed from the next state so the flop tracks the FSM with no lag.
        case (state_nxt_s)
            S_START: tx_nxt_s = 1'b0;
            S_DATA:  tx_nxt_s = shift_nxt_s[0];
            default: tx_nxt_s = 1'b1;
        endcase

        irq_nxt_s = irq_en_r & fifo_empty_s & (state_r == S_IDLE);
    end

    // serialiser datapath and output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            irq_r      <= 1'b0;
        end else begin
            baud_cnt_r <= baud_nxt_s;
            bit_idx_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
            irq_r      <= irq_nxt_s;
        end
    end

    assign uart_tx       = tx_r;
    assign tx_irq        = irq_r;
    assign bus_read_data = rdata_r;

endmodule

// File: tb/tb_uart_tx_bus.sv
// Directed bench for uart_tx_bus with DIV=4: frame timing, FIFO overflow,
// back-to-back frames, mid-frame reset and the idle interrupt.
module tb_uart_tx_bus;

    localparam logic [63:0] A_TX    = 64'h8000_0000;
    localparam logic [63:0] A_ST    = 64'h8000_0008;
    localparam logic [63:0] A_CTRL  = 64'h8000_0010;
    localparam logic [63:0] A_RSVD  = 64'h8000_0018;
    localparam logic [63:0] A_OTHER = 64'h9000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        uart_tx;
    logic        tx_irq;

    int   errors = 0;
    int   checks = 0;
    logic samp [0:99];
    logic count_en = 1'b0;
    logic prev_tx;
    int   falls;

    always #5 clk = ~clk;

    uart_tx_bus #(
        .CLK_HZ     (460800),
        .BAUD       (115200),
        .FIFO_DEPTH (16),
        .BASE_ADDR  (64'h8000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .uart_tx          (uart_tx),
        .tx_irq           (tx_irq)
    );

    // count start-bit falling edges while enabled
    always @(negedge clk) begin
        if (!count_en) falls <= 0;
        else if (prev_tx === 1'b1 && uart_tx === 1'b0) falls <= falls + 1;
        prev_tx <= uart_tx;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] d, input int hold);
        @(negedge clk);
        bus_address      = a;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        repeat (hold) @(negedge clk);
        bus_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
        @(negedge clk);
        bus_address     = a;
        bus_read_enable = 1'b1;
        @(negedge clk);
        bus_read_enable = 1'b0;
        d = bus_read_data;
    endtask

    // wait (bounded) for a low line, then record n samples starting with it
    task automatic capture(input int budget, input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("start_seen", 64'(found), 64'd1);
        samp[0] = uart_tx;
        for (int j = 1; j < n; j++) begin
            @(negedge clk);
            samp[j] = uart_tx;
        end
    endtask

    task automatic check_frame(input int base, input logic [7:0] b, input string tag);
        for (int i = 0; i < 10; i++) begin
            logic       e;
            logic [3:0] g;
            e = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
            g = {samp[base+4*i], samp[base+4*i+1], samp[base+4*i+2], samp[base+4*i+3]};
            check_eq($sformatf("%s_bit%0d", tag, i), 64'(g), 64'({4{e}}));
        end
    endtask

    task automatic count_low_samples(input int from, input int to, output int n);
        n = 0;
        for (int i = from; i < to; i++) if (samp[i] !== 1'b1) n++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int          n;
        int          first_hi;

        reset            = 1'b0;
        bus_address      = 64'd0;
        bus_write_data   = 64'd0;
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 64'(uart_tx), 64'd1);
        check_eq("rst_irq", 64'(tx_irq), 64'd0);
        check_eq("rst_rdata", bus_read_data, 64'd0);
        reset = 1'b1;
        bus_read(A_ST, d);   check_eq("rst_status", d, 64'h2);
        bus_read(A_CTRL, d); check_eq("rst_ctrl", d, 64'h0);
        bus_read(A_RSVD, d); check_eq("rsvd_read", d, 64'h0);
        bus_read(A_OTHER + 64'h8, d); check_eq("unsel_read", d, 64'h0);

        // unselected and reserved writes must not act
        bus_write(A_OTHER, 64'h33, 1);
        bus_write(A_RSVD, 64'h1, 1);
        repeat (3) @(negedge clk);
        bus_read(A_ST, d);   check_eq("unsel_write_status", d, 64'h2);
        bus_read(A_CTRL, d); check_eq("rsvd_write_ctrl", d, 64'h0);

        // enable held five cycles: exactly one frame of 0x41
        fork
            bus_write(A_TX, 64'h41, 5);
            capture(20, 60);
        join
        check_frame(0, 8'h41, "held");
        count_low_samples(40, 60, n);
        check_eq("held_single_frame", 64'(n), 64'd0);
        bus_read(A_ST, d); check_eq("held_status_after", d, 64'h2);

        // 18 writes: 1 in the shifter, 16 queued, 1 dropped
        count_en = 1'b1;
        for (int k = 0; k < 18; k++) bus_write(A_TX, 64'hFF, 1);
        bus_read(A_ST, d); check_eq("ovf_status", d, 64'h10D);  // full|busy|ovf|count=16
        bus_read(A_ST, d); check_eq("ovf_cleared", d, 64'h105); // full|busy|count=16
        repeat (720) @(negedge clk);
        check_eq("ovf_frames_sent", 64'(falls), 64'd17);
        count_en = 1'b0;
        bus_read(A_ST, d); check_eq("drained_status", d, 64'h2);

        // two bytes back-to-back: 80 contiguous cycles
        fork
            begin
                bus_write(A_TX, 64'h55, 1);
                bus_write(A_TX, 64'hAA, 1);
            end
            capture(20, 90);
        join
        check_frame(0, 8'h55, "b2b_a");
        check_frame(40, 8'hAA, "b2b_b");
        count_low_samples(80, 90, n);
        check_eq("b2b_idle_after", 64'(n), 64'd0);

        // asynchronous reset during data bit 3 of 0x00
        bus_write(A_TX, 64'h00, 1);
        capture(20, 1);
        bus_read(A_ST, d); check_eq("busy_status", d, 64'h6);
        repeat (15) @(negedge clk);
        check_eq("mid_bit3_low", 64'(uart_tx), 64'd0);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_tx", 64'(uart_tx), 64'd1);
        check_eq("async_rst_rdata", bus_read_data, 64'd0);
        check_eq("async_rst_irq", 64'(tx_irq), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_ST, d); check_eq("post_rst_status", d, 64'h2);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) n++;
        end
        check_eq("post_rst_quiet", 64'(n), 64'd0);

        // idle interrupt
        bus_write(A_CTRL, 64'h1, 1);
        bus_read(A_CTRL, d); check_eq("ctrl_readback", d, 64'h1);
        @(negedge clk);
        check_eq("irq_idle_high", 64'(tx_irq), 64'd1);
        bus_write(A_TX, 64'h00, 1);
        first_hi = -1;
        for (int c = 2; c < 60; c++) begin
            @(negedge clk);
            if (c == 2) check_eq("irq_drop", 64'(tx_irq), 64'd0);
            if (tx_irq === 1'b1 && first_hi < 0) first_hi = c;
        end
        check_eq("irq_return_cycle", 64'(first_hi), 64'd43);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
